fpu_issue_arbiter: RTL and testbench
====================================

# fpu_issue_arbiter

Shares one pipelined FPU datapath between two requesters. Accepts operand pairs over valid/ready handshakes, arbitrates round-robin, and issues at most one operation per cycle into the pipeline. The pipeline's stage registers carry no valid or owner information, so this block tracks validity and owner in a shift register matched to the pipeline depth. It routes each result and error flag back to the requester that issued it.

## Interface
- LAT, 3: cycles from `fpu_issue` cycle to result valid at pipeline output (≥1)
- MAX_OUT, 4: max outstanding ops per requester (1..15)
- clk  in  1  clock, rising edge
- nRESET  in  1  asynchronous active-low reset
- req0_valid / req1_valid  in  1  requester has an op
- req0_ready / req1_ready  out  1  op accepted this cycle
- req0_a, req0_b / req1_a, req1_b  in  32  IEEE-754 single operands
- fpu_issue  out  1  registered; operands on fpu_a/fpu_b are live this cycle
- fpu_a, fpu_b  out  32  registered operands to stage 1
- fpu_result  in  32  pipeline output word
- fpu_error  in  1  pipeline error flag, aligned with fpu_result
- rsp0_valid / rsp1_valid  out  1  registered one-cycle result strobe
- rsp0_data / rsp1_data  out  32  result, valid with strobe
- rsp0_error / rsp1_error  out  1  error, valid with strobe

## Operation
- Eligibility: `elig_i = req_i_valid & (cnt_i < MAX_OUT)`.
- Winner when both are eligible: requester at `ptr`. When only one is eligible, that one wins.
- `req_i_ready = elig_i & (winner == i)`. Ready is combinational and may depend on the other requester's valid. At most one ready is high per cycle.
- Accept on edge with `req_i_valid & req_i_ready`:
  - fpu_a/fpu_b load the operands.
  - fpu_issue is set to 1 for the next cycle.
  - `ptr <= ~i`.
- With no accept, fpu_issue is 0, fpu_a/fpu_b hold, and ptr holds.
- Tag pipe: shift register `LAT` deep of {valid, owner}. It is loaded with {fpu_issue, owner of issued op} each cycle and shifts unconditionally. The pipeline never stalls.
- When the tag-pipe output valid = 1, the block registers fpu_result and fpu_error into rsp_owner data/error and pulses rsp_owner_valid for one cycle.
- Non-owner rsp_data holds its previous value.
- Responses have no backpressure; requesters must sink them.
- Counters `cnt_i` (4 bit):
  - +1 on accept.
  - −1 on rsp_i_valid.
  - Both in the same cycle: unchanged.
  - Never exceeds MAX_OUT and never underflows. Violation of either is an assertion failure.
- Results return in issue order. Interleaving between requesters is preserved.

## Timing
- Accept at edge E0. fpu_issue is high in cycle E0..E1. The result is at the pipeline output LAT cycles later. rsp_valid is high in the cycle after that.
- Accept-to-response latency is LAT+2 cycles; 5 at default.
- Throughput is 1 op/cycle aggregate. With both requesters continuously eligible, grants strictly alternate.
- MAX_OUT reached: ready drops the cycle after the MAX_OUT-th accept. Ready returns in the cycle rsp_i_valid is high, because the decrement is visible combinationally via `cnt_i − rsp_i_valid`.
- Reset (async, any time):
  - Every output is 0: req_ready, fpu_issue, fpu_a, fpu_b, rsp valid/data/error.
  - ptr = 0 and cnt = 0.
  - The tag pipe is cleared, so ops already in the FPU are discarded and their later results never produce rsp_valid.
- First cycle after reset release: if both requesters are valid, req0 wins.

## Test plan
- **Single op.** At LAT=3, req0 sends a=0x3F800000, b=0x40000000 and is accepted at cycle 1. Required: fpu_issue in cycle 2 with those operands. A stub pipeline returns 0x40000000 at cycle 5. rsp0_valid=1 with data 0x40000000 in cycle 6. rsp1_valid stays 0.
- **Contention.** Both requesters valid continuously for 8 cycles. Required: grants go 0,1,0,1,… starting with req0. Responses return in the same alternating order with correct owner routing.
- **Outstanding limit.** MAX_OUT=4, req1 only, responses withheld by LAT=3 plus a long stream. Required: req1_ready drops after 4 accepts and reasserts in the cycle the first rsp1_valid fires. cnt1 never exceeds 4.
- **Error routing.** The stub asserts fpu_error on req1's op only, within interleaved traffic. Required: rsp1_error=1 on that strobe only; rsp0_error stays 0.
- **Mid-flight reset.** Issue 3 ops, then pulse nRESET low for 1 cycle while they are in flight. Required: all outputs are 0 during reset and no rsp_valid appears afterwards. Counters restart at 0, and a new op completes with the normal LAT+2 latency.

Source files
------------

// File: rtl/fpu_issue_arbiter.sv
// -----------------------------------------------------------------------------
// fpu_issue_arbiter
//
// Shares one pipelined FPU datapath between two requesters. Operand pairs are
// accepted over valid/ready handshakes, arbitrated round-robin, and at most
// one operation per cycle is issued into the pipeline. The FPU stage registers
// carry no valid/owner information, so a LAT-deep tag pipe tracks which cycles
// hold live results and who issued them; results and error flags are steered
// back to the issuing requester.
//
// Parameters
//   LAT      cycles from fpu_issue to result at the pipeline output (>= 1)
//   MAX_OUT  max outstanding ops per requester (1..15)
//
// Ports
//   clk, nRESET                 clock (rising edge), async active-low reset
//   reqN_valid/_ready           request handshake (ready is combinational)
//   reqN_a, reqN_b              single-precision operands
//   fpu_issue, fpu_a, fpu_b     registered issue strobe and operands to stage 1
//   fpu_result, fpu_error       pipeline output word and its error flag
//   rspN_valid/_data/_error     registered one-cycle response per requester
// -----------------------------------------------------------------------------
module fpu_issue_arbiter #(
    parameter int unsigned LAT     = 3,
    parameter int unsigned MAX_OUT = 4
) (
    input  logic        clk,
    input  logic        nRESET,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,

    output logic        fpu_issue,
    output logic [31:0] fpu_a,
    output logic [31:0] fpu_b,
    input  logic [31:0] fpu_result,
    input  logic        fpu_error,

    output logic        rsp0_valid,
    output logic [31:0] rsp0_data,
    output logic        rsp0_error,

    output logic        rsp1_valid,
    output logic [31:0] rsp1_data,
    output logic        rsp1_error
);

    localparam int unsigned CNT_W = 4;

    // Outstanding-op counters and the round-robin pointer
    logic [CNT_W-1:0] cnt0, cnt1;
    logic [CNT_W-1:0] cnt0_eff, cnt1_eff;
    logic [CNT_W-1:0] cnt0_nxt, cnt1_nxt;
    logic             ptr;

    // Arbitration terms
    logic elig0, elig1;
    logic winner;
    logic acc0, acc1;

    // Owner of the op currently on fpu_a/fpu_b
    logic issue_owner;

    // Tag pipe: bit [0] is the youngest entry, bit [LAT-1] lines up with fpu_result
    logic [LAT-1:0] tag_v;
    logic [LAT-1:0] tag_o;
    logic           tag_out_v;
    logic           tag_out_o;

    // Eligibility and grant. A response strobe this cycle frees a slot
    // immediately, so the limit is checked against cnt - rsp_valid.
    always_comb begin
        cnt0_eff = cnt0 - CNT_W'(rsp0_valid);
        cnt1_eff = cnt1 - CNT_W'(rsp1_valid);
        elig0    = req0_valid & (cnt0_eff < CNT_W'(MAX_OUT));
        elig1    = req1_valid & (cnt1_eff < CNT_W'(MAX_OUT));

        winner = 1'b0;
        if (elig0 && elig1) begin
            winner = ptr;
        end else if (elig1) begin
            winner = 1'b1;
        end

        // Ready is forced low while reset is asserted
        req0_ready = nRESET & elig0 & ~winner;
        req1_ready = nRESET & elig1 & winner;

        acc0 = req0_valid & req0_ready;
        acc1 = req1_valid & req1_ready;
    end

    // Counter next state: accept and response in the same cycle cancel out
    always_comb begin
        cnt0_nxt = cnt0 + CNT_W'(acc0) - CNT_W'(rsp0_valid);
        cnt1_nxt = cnt1 + CNT_W'(acc1) - CNT_W'(rsp1_valid);
    end

    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            cnt0 <= cnt0_nxt;
            cnt1 <= cnt1_nxt;
        end
    end

    // Issue register: operands hold when nothing is accepted
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            fpu_issue   <= 1'b0;
            fpu_a       <= '0;
            fpu_b       <= '0;
            issue_owner <= 1'b0;
            ptr         <= 1'b0;
        end else if (acc0) begin
            fpu_issue   <= 1'b1;
            fpu_a       <= req0_a;
            fpu_b       <= req0_b;
            issue_owner <= 1'b0;
            ptr         <= 1'b1;
        end else if (acc1) begin
            fpu_issue   <= 1'b1;
            fpu_a       <= req1_a;
            fpu_b       <= req1_b;
            issue_owner <= 1'b1;
            ptr         <= 1'b0;
        end else begin
            fpu_issue   <= 1'b0;
        end
    end

    // Tag pipe shifts every cycle; the FPU never stalls. Clearing it on reset
    // drops any ops still inside the datapath.
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            tag_v <= '0;
            tag_o <= '0;
        end else begin
            tag_v <= LAT'({tag_v, fpu_issue});
            tag_o <= LAT'({tag_o, issue_owner});
        end
    end

    always_comb begin
        tag_out_v = tag_v[LAT-1];
        tag_out_o = tag_o[LAT-1];
    end

    // Response steering: owner gets a one-cycle strobe, the other side's
    // data word is left untouched.
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            rsp0_valid <= 1'b0;
            rsp0_data  <= '0;
            rsp0_error <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp1_data  <= '0;
            rsp1_error <= 1'b0;
        end else begin
            rsp0_valid <= tag_out_v & ~tag_out_o;
            rsp1_valid <= tag_out_v &  tag_out_o;
            rsp0_error <= tag_out_v & ~tag_out_o & fpu_error;
            rsp1_error <= tag_out_v &  tag_out_o & fpu_error;
            if (tag_out_v && !tag_out_o) begin
                rsp0_data <= fpu_result;
            end
            if (tag_out_v && tag_out_o) begin
                rsp1_data <= fpu_result;
            end
        end
    end

    // Counter sanity: bounded by MAX_OUT, no response without an outstanding op
    always @(posedge clk) begin
        if (nRESET) begin
            assert (cnt0 <= CNT_W'(MAX_OUT));
            assert (cnt1 <= CNT_W'(MAX_OUT));
            assert (!(rsp0_valid && (cnt0 == '0)));
            assert (!(rsp1_valid && (cnt1 == '0)));
        end
    end

endmodule

// File: tb/tb_fpu_issue_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fpu_issue_arbiter
//
// Drives fpu_issue_arbiter with a stub LAT-stage pipeline. Every accepted op
// pushes its expected owner/result/error/accept-cycle into a queue; every
// response strobe pops and compares. Scenario tasks add their own checks for
// grant order, ready timing, error routing and reset behaviour.
// -----------------------------------------------------------------------------
module tb_fpu_issue_arbiter;

    localparam int unsigned LAT     = 3;
    localparam int unsigned MAX_OUT = 4;

    logic        clk;
    logic        nRESET;
    logic        req0_valid, req0_ready;
    logic [31:0] req0_a, req0_b;
    logic        req1_valid, req1_ready;
    logic [31:0] req1_a, req1_b;
    logic        fpu_issue;
    logic [31:0] fpu_a, fpu_b;
    logic [31:0] fpu_result;
    logic        fpu_error;
    logic        rsp0_valid, rsp0_error;
    logic [31:0] rsp0_data;
    logic        rsp1_valid, rsp1_error;
    logic [31:0] rsp1_data;

    fpu_issue_arbiter #(.LAT(LAT), .MAX_OUT(MAX_OUT)) dut (
        .clk        (clk),
        .nRESET     (nRESET),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .fpu_issue  (fpu_issue),
        .fpu_a      (fpu_a),
        .fpu_b      (fpu_b),
        .fpu_result (fpu_result),
        .fpu_error  (fpu_error),
        .rsp0_valid (rsp0_valid),
        .rsp0_data  (rsp0_data),
        .rsp0_error (rsp0_error),
        .rsp1_valid (rsp1_valid),
        .rsp1_data  (rsp1_data),
        .rsp1_error (rsp1_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Stub FPU: result = b ^ a[15:0], error when a[15:0] == 16'hBAD0
    function automatic logic [31:0] stub_res(input logic [31:0] a, input logic [31:0] b);
        return b ^ {16'h0000, a[15:0]};
    endfunction

    function automatic logic stub_err(input logic [31:0] a);
        return (a[15:0] == 16'hBAD0);
    endfunction

    logic [31:0] pr [LAT];
    logic        pe [LAT];
    always @(posedge clk) begin
        pr[0] <= stub_res(fpu_a, fpu_b);
        pe[0] <= stub_err(fpu_a);
        for (int i = 1; i < int'(LAT); i++) begin
            pr[i] <= pr[i-1];
            pe[i] <= pe[i-1];
        end
    end
    assign fpu_result = pr[LAT-1];
    assign fpu_error  = pe[LAT-1];

    typedef struct {
        logic        owner;
        logic [31:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: push on accept, pop and compare on each response strobe
    task automatic monitor();
        exp_t e;
        logic [31:0] got_d;
        logic        got_e;
        forever begin
            @(negedge clk);
            if (nRESET) begin
                total++;
                if (req0_ready && req1_ready) begin
                    bad++;
                    $display("FAIL both_ready: got 11 required at most one");
                end
                if (rsp0_valid || rsp1_valid) begin
                    total++;
                    if (sb.size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_rsp: got rsp0=%0b rsp1=%0b at cyc %0d required none",
                                 rsp0_valid, rsp1_valid, cyc);
                    end else begin
                        e = sb.pop_front();
                        if ({rsp1_valid, rsp0_valid} !== (e.owner ? 2'b10 : 2'b01)) begin
                            bad++;
                            $display("FAIL rsp_owner: got {rsp1,rsp0}=%b required owner %0d",
                                     {rsp1_valid, rsp0_valid}, e.owner);
                        end
                        got_d = e.owner ? rsp1_data  : rsp0_data;
                        got_e = e.owner ? rsp1_error : rsp0_error;
                        total++;
                        if (got_d !== e.data) begin
                            bad++;
                            $display("FAIL rsp_data: got %h required %h", got_d, e.data);
                        end
                        total++;
                        if (got_e !== e.err) begin
                            bad++;
                            $display("FAIL rsp_error: got %0b required %0b", got_e, e.err);
                        end
                        total++;
                        if ((cyc - e.cyc) !== int'(LAT) + 2) begin
                            bad++;
                            $display("FAIL rsp_latency: got %0d required %0d", cyc - e.cyc, LAT + 2);
                        end
                    end
                end
                if (req0_valid && req0_ready)
                    sb.push_back('{1'b0, stub_res(req0_a, req0_b), stub_err(req0_a), cyc});
                if (req1_valid && req1_ready)
                    sb.push_back('{1'b1, stub_res(req1_a, req1_b), stub_err(req1_a), cyc});
            end
        end
    endtask

    task automatic drain(input int n);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (n) next_cycle();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending required 0", sb.size());
        end
    endtask

    task automatic test_reset();
        nRESET = 1'b0;
        req0_valid = 1'b1; req0_a = 32'h1111_1111; req0_b = 32'h2222_2222;
        req1_valid = 1'b1; req1_a = 32'h3333_3333; req1_b = 32'h4444_4444;
        repeat (2) @(negedge clk);
        total++;
        if ({req0_ready, req1_ready, fpu_issue} !== 3'b000) begin
            bad++;
            $display("FAIL reset_ctrl: got %b required 000", {req0_ready, req1_ready, fpu_issue});
        end
        total++;
        if ({rsp0_valid, rsp1_valid, rsp0_error, rsp1_error} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_rsp: got %b required 0000", {rsp0_valid, rsp1_valid, rsp0_error, rsp1_error});
        end
        total++;
        if ({fpu_a, fpu_b} !== 64'h0) begin
            bad++;
            $display("FAIL reset_fpu_ops: got %h required 0", {fpu_a, fpu_b});
        end
        total++;
        if ({rsp0_data, rsp1_data} !== 64'h0) begin
            bad++;
            $display("FAIL reset_rsp_data: got %h required 0", {rsp0_data, rsp1_data});
        end
        next_cycle();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        nRESET = 1'b1;
    endtask

    task automatic test_contention();
        logic [1:0] expv;
        next_cycle();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            expv = (k % 2 == 1) ? 2'b10 : 2'b01;
            total++;
            if ({req1_ready, req0_ready} !== expv) begin
                bad++;
                $display("FAIL contention_grant k=%0d: got {r1,r0}=%b required %b",
                         k, {req1_ready, req0_ready}, expv);
            end
            next_cycle();
            req0_a = 32'h3F80_0000 + 32'(k);  req0_b = 32'h4000_0100 + 32'(k);
            req1_a = 32'h4040_0020 + 32'(k);  req1_b = 32'h4080_3000 + 32'(k);
        end
        drain(12);
    endtask

    task automatic test_single();
        next_cycle();
        req0_valid = 1'b1; req0_a = 32'h3F80_0000; req0_b = 32'h4000_0000;
        @(negedge clk);
        total++;
        if (req0_ready !== 1'b1) begin
            bad++;
            $display("FAIL single_ready: got %0b required 1", req0_ready);
        end
        next_cycle();
        req0_valid = 1'b0; req0_a = 32'h0; req0_b = 32'h0;
        @(negedge clk);
        total++;
        if ({fpu_issue, fpu_a, fpu_b} !== {1'b1, 32'h3F80_0000, 32'h4000_0000}) begin
            bad++;
            $display("FAIL single_issue: got %0b %h %h required 1 3f800000 40000000",
                     fpu_issue, fpu_a, fpu_b);
        end
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (i == 1) begin
                total++;
                if ({fpu_issue, fpu_a} !== {1'b0, 32'h3F80_0000}) begin
                    bad++;
                    $display("FAIL single_hold: got %0b %h required 0 3f800000", fpu_issue, fpu_a);
                end
            end
            total++;
            if (rsp1_valid !== 1'b0) begin
                bad++;
                $display("FAIL single_rsp1: got %0b required 0", rsp1_valid);
            end
            total++;
            if (i < 4 && rsp0_valid !== 1'b0) begin
                bad++;
                $display("FAIL single_early i=%0d: got %0b required 0", i, rsp0_valid);
            end else if (i == 4 && {rsp0_valid, rsp0_data} !== {1'b1, 32'h4000_0000}) begin
                bad++;
                $display("FAIL single_rsp0: got %0b %h required 1 40000000", rsp0_valid, rsp0_data);
            end
        end
        drain(8);
    endtask

    task automatic test_limit();
        logic exp_rdy;
        next_cycle();
        req1_valid = 1'b1; req1_a = 32'h4100_0000; req1_b = 32'h4200_0000;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            exp_rdy = (k % 5 != 4);
            total++;
            if (req1_ready !== exp_rdy) begin
                bad++;
                $display("FAIL limit_ready k=%0d: got %0b required %0b", k, req1_ready, exp_rdy);
            end
            if (k == 5) begin
                total++;
                if ({rsp1_valid, req1_ready} !== 2'b11) begin
                    bad++;
                    $display("FAIL limit_reassert: got rsp1/ready=%b required 11", {rsp1_valid, req1_ready});
                end
            end
            next_cycle();
            req1_a = 32'h4100_0001 + 32'(k);  req1_b = 32'h4200_0010 + 32'(k);
        end
        drain(12);
    endtask

    task automatic test_error();
        int   errs0 = 0;
        int   errs1 = 0;
        logic sent  = 1'b0;
        next_cycle();
        req0_valid = 1'b1; req0_a = 32'h3F00_0000; req0_b = 32'h3F00_1234;
        req1_valid = 1'b1; req1_a = 32'h4040_BAD0; req1_b = 32'h4040_5678;
        for (int k = 0; k < 18; k++) begin
            @(negedge clk);
            if (rsp0_error) errs0++;
            if (rsp1_error) errs1++;
            if (req1_valid && req1_ready) sent = 1'b1;
            next_cycle();
            if (k < 5) begin
                req0_a = 32'h3F00_0001 + 32'(k);
                req1_a = sent ? (32'h3E00_0001 + 32'(k)) : 32'h4040_BAD0;
            end else begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
        end
        total++;
        if (errs1 != 1) begin
            bad++;
            $display("FAIL error_rsp1: got %0d strobes required 1", errs1);
        end
        total++;
        if (errs0 != 0) begin
            bad++;
            $display("FAIL error_rsp0: got %0d strobes required 0", errs0);
        end
        drain(4);
    endtask

    task automatic test_midreset();
        int stray = 0;
        next_cycle();
        req0_valid = 1'b1; req0_a = 32'h3F80_0000; req0_b = 32'h4000_0001;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++;
            if (req0_ready !== 1'b1) begin
                bad++;
                $display("FAIL midreset_issue k=%0d: got %0b required 1", k, req0_ready);
            end
            next_cycle();
            req0_b = 32'h4000_0002 + 32'(k);
        end
        req0_valid = 1'b0;
        nRESET = 1'b0;
        @(negedge clk);
        total++;
        if ({req0_ready, req1_ready, fpu_issue, rsp0_valid, rsp1_valid, rsp0_error, rsp1_error} !== 7'b0) begin
            bad++;
            $display("FAIL midreset_ctrl: got %b required 0000000",
                     {req0_ready, req1_ready, fpu_issue, rsp0_valid, rsp1_valid, rsp0_error, rsp1_error});
        end
        total++;
        if ({fpu_a, fpu_b, rsp0_data, rsp1_data} !== 128'h0) begin
            bad++;
            $display("FAIL midreset_data: got %h required 0", {fpu_a, fpu_b, rsp0_data, rsp1_data});
        end
        sb.delete();
        next_cycle();
        nRESET = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp0_valid || rsp1_valid) stray++;
        end
        total++;
        if (stray != 0) begin
            bad++;
            $display("FAIL midreset_stray: got %0d strobes required 0", stray);
        end
        next_cycle();
        req0_valid = 1'b1; req0_a = 32'h4000_0000; req0_b = 32'h4100_0000;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            total++;
            if (req0_ready !== 1'b1) begin
                bad++;
                $display("FAIL midreset_cnt k=%0d: got %0b required 1", k, req0_ready);
            end
            next_cycle();
            req0_b = 32'h4100_0001 + 32'(k);
        end
        drain(10);
    endtask

    initial begin
        nRESET = 1'b0;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0;
        fork
            monitor();
        join_none
        test_reset();
        test_contention();
        test_single();
        test_limit();
        test_error();
        test_midreset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
